// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: state geometry, GF(2^8) reduction constant,
// the MixColumns sequencer FSM encoding and the xtime helper.
package aes_pkg;

  localparam int         AES_STATE_W = 128;
  localparam int         AES_COL_W   = 32;
  localparam int         AES_NCOL    = 4;
  localparam logic [7:0] GF_POLY     = 8'h1B;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mixseq_state_t;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mix_col.sv
// Combinational MixColumns of a single 32-bit column; byte 0 is the MSB byte.
module mix_col
  import aes_pkg::*;
(
  input  logic [AES_COL_W-1:0] col_i,
  output logic [AES_COL_W-1:0] col_o
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] b0, b1, b2, b3;

  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  // 3*a is xtime(a)^a, so each row is two xtimes plus a plain byte XOR
  assign b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
  assign b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
  assign b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
  assign b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);

  assign col_o = {b0, b1, b2, b3};

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns: LANES columns per cycle through shared mix_col lanes.
// Optional final-round pass-through port last_round when MIXCOL_BYPASS_EN is defined.
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state
`ifdef MIXCOL_BYPASS_EN
  ,
  input  logic                   last_round
`endif
);

  localparam int            NCYC     = AES_NCOL / LANES;
  localparam int            CW       = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NCYC - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("mix_columns_seq: LANES must be 1, 2 or 4");
  end

  mixseq_state_t        state_q;
  logic [CW-1:0]        cnt_q;
  logic                 out_valid_q;
  logic [AES_COL_W-1:0] src_q [AES_NCOL];
  logic [AES_COL_W-1:0] res_q [AES_NCOL];

  logic [AES_COL_W-1:0] lane_in  [LANES];
  logic [AES_COL_W-1:0] lane_out [LANES];
  logic [1:0]           lane_col [LANES];
  logic                 accept;
  logic                 bypass;

`ifdef MIXCOL_BYPASS_EN
  assign bypass = last_round;
`else
  assign bypass = 1'b0;
`endif

  // Lane l of cycle k handles column k*LANES+l
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_col[l] = 2'(int'(cnt_q) * LANES + l);
    assign lane_in[l]  = src_q[lane_col[l]];
    mix_col u_mix (
      .col_i (lane_in[l]),
      .col_o (lane_out[l])
    );
  end

  assign in_ready  = rst_n & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign out_state = {res_q[0], res_q[1], res_q[2], res_q[3]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      for (int c = 0; c < AES_NCOL; c++) begin
        src_q[c] <= '0;
        res_q[c] <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            if (bypass) begin
              for (int c = 0; c < AES_NCOL; c++)
                res_q[c] <= in_state[AES_STATE_W-1-AES_COL_W*c -: AES_COL_W];
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              for (int c = 0; c < AES_NCOL; c++)
                src_q[c] <= in_state[AES_STATE_W-1-AES_COL_W*c -: AES_COL_W];
              cnt_q       <= '0;
              state_q     <= RUN;
              out_valid_q <= 1'b0;
            end
          end else if (state_q == DONE && out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        RUN: begin
          for (int l = 0; l < LANES; l++)
            res_q[lane_col[l]] <= lane_out[l];
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq (LANES=1 and LANES=4 instances).
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, out_ready, last_round, sel;
  logic [127:0] in_state;
  logic         ir1, ov1, ir4, ov4;
  logic [127:0] os1, os4;
  logic         ir, ov;
  logic [127:0] os;

  int           ncmp = 0;
  int           nerr = 0;
  logic [127:0] q[$];

  always #5 clk = ~clk;

  assign ir = sel ? ir4 : ir1;
  assign ov = sel ? ov4 : ov1;
  assign os = sel ? os4 : os1;

  mix_columns_seq #(.LANES(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid & ~sel),
    .in_ready  (ir1),
    .in_state  (in_state),
    .out_valid (ov1),
    .out_ready (out_ready),
    .out_state (os1)
`ifdef MIXCOL_BYPASS_EN
    ,
    .last_round(last_round)
`endif
  );

  mix_columns_seq #(.LANES(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid & sel),
    .in_ready  (ir4),
    .in_state  (in_state),
    .out_valid (ov4),
    .out_ready (out_ready),
    .out_state (os4)
`ifdef MIXCOL_BYPASS_EN
    ,
    .last_round(last_round)
`endif
  );

  // Reference model: generic GF(2^8) multiply and the circulant MixColumns matrix
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] aa;
    logic [7:0] p;
    aa = {1'b0, a};
    p  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa[7:0];
      aa = aa << 1;
      if (aa[8]) aa = aa ^ 9'h11B;
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_model(input logic [127:0] s);
    logic [7:0]   coef [4];
    logic [7:0]   a    [4];
    logic [7:0]   b;
    logic [127:0] r;
    coef[0] = 8'd2; coef[1] = 8'd3; coef[2] = 8'd1; coef[3] = 8'd1;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
      for (int row = 0; row < 4; row++) begin
        b = 8'h00;
        for (int k = 0; k < 4; k++) b = b ^ gmul(coef[(k - row + 4) % 4], a[k]);
        r[127 - 32*c - 8*row -: 8] = b;
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_result(output int lat, output int low, output logic [127:0] res);
    lat = 0;
    low = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!ov && !ir) low++;
    end while (!ov && lat < 30);
    res = os;
  endtask

  task automatic send(input logic [127:0] st, input logic lr,
                      output int lat, output int low, output logic [127:0] res);
    int guard;
    guard = 0;
    @(negedge clk);
    in_state   = st;
    last_round = lr;
    in_valid   = 1'b1;
    #1;
    while (!ir && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!ir) chk("accept_timeout", ir, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_result(lat, low, res);
  endtask

  task automatic run_random(input int n);
    int   sent, got, cyc;
    logic acc;
    sent = 0; got = 0; cyc = 0;
    q.delete();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    while ((sent < n || q.size() != 0) && cyc < n * 40) begin
      @(negedge clk);
      cyc++;
      if (!in_valid && sent < n && $urandom_range(3) != 0) begin
        in_state = {$urandom, $urandom, $urandom, $urandom};
`ifdef MIXCOL_BYPASS_EN
        last_round = ($urandom_range(3) == 0);
`else
        last_round = 1'b0;
`endif
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(3) != 0);
      #1;
      if (ov && out_ready) begin
        if (q.size() == 0) chk("rnd_spurious_out", ov, 1'b0);
        else chk("rnd_data", os, q.pop_front());
        got++;
      end
      acc = in_valid && ir;
      if (acc) begin
        q.push_back(last_round ? in_state : mix_model(in_state));
        sent++;
      end
      @(posedge clk);
      #1;
      if (acc) in_valid = 1'b0;
    end
    chk("rnd_blocks_out", got, n);
    chk("rnd_pending", q.size(), 0);
    out_ready = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int           lat, low;
    logic [127:0] res, st1, st2, exp1;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_state = '0; last_round = 1'b0; sel = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_out_valid1", ov1, 1'b0);
    chk("rst_out_state1", os1, 128'h0);
    chk("rst_in_ready1", ir1, 1'b0);
    chk("rst_out_valid4", ov4, 1'b0);
    chk("rst_in_ready4", ir4, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("idle_in_ready1", ir1, 1'b1);

    // Single block on LANES=1
    out_ready = 1'b1;
    send(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, lat, low, res);
    chk("l1_result", res, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
    chk("l1_latency", lat, 5);
    chk("l1_ready_low", low, 4);
    @(negedge clk);
    chk("l1_consumed", ov, 1'b0);

    // Single block on LANES=4
    sel = 1'b1;
    send(128'hd4d4d4d5_2d26314c_00000000_ffffffff, 1'b0, lat, low, res);
    chk("l4_result", res, 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff);
    chk("l4_latency", lat, 2);
    @(negedge clk);
    chk("l4_consumed", ov, 1'b0);
    sel = 1'b0;

    // Backpressure, then simultaneous output and input handshakes
    st1  = {$urandom, $urandom, $urandom, $urandom};
    st2  = {$urandom, $urandom, $urandom, $urandom};
    exp1 = mix_model(st1);
    out_ready = 1'b0;
    send(st1, 1'b0, lat, low, res);
    chk("bp_latency", lat, 5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_state", os, exp1);
      chk("bp_hold_valid", ov, 1'b1);
      chk("bp_in_ready", ir, 1'b0);
    end
    @(negedge clk);
    in_state = st2; last_round = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", ir, 1'b1);
    chk("b2b_out_state", os, exp1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_result(lat, low, res);
    chk("b2b_latency", lat, 5);
    chk("b2b_result", res, mix_model(st2));
    @(negedge clk);

    // Reset during the second RUN cycle
    st1 = {$urandom, $urandom, $urandom, $urandom} | 128'h01000000_00000000_00000000_00000000;
    in_state = st1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstrun_out_valid", ov, 1'b0);
    chk("rstrun_out_state", os, 128'h0);
    chk("rstrun_in_ready", ir, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstrun_ready_after", ir, 1'b1);
    st2 = {$urandom, $urandom, $urandom, $urandom};
    send(st2, 1'b0, lat, low, res);
    chk("rstrun_next_result", res, mix_model(st2));
    chk("rstrun_next_latency", lat, 5);
    @(negedge clk);

`ifdef MIXCOL_BYPASS_EN
    send(128'h00112233_44556677_8899aabb_ccddeeff, 1'b1, lat, low, res);
    chk("byp_result", res, 128'h00112233_44556677_8899aabb_ccddeeff);
    chk("byp_latency", lat, 1);
    @(negedge clk);
    st1 = {$urandom, $urandom, $urandom, $urandom};
    send(st1, 1'b0, lat, low, res);
    chk("byp_off_result", res, mix_model(st1));
    chk("byp_off_latency", lat, 5);
    @(negedge clk);
`endif

    // Randomized traffic: 600 blocks on LANES=1, 400 on LANES=4
    sel = 1'b0;
    run_random(600);
    @(negedge clk);
    sel = 1'b1;
    run_random(400);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
